// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } sup_state_t;

  localparam logic [7:0] CNT8_MAX = 8'hFF;

  // Wide enough that the largest phase length fits with a spare bit, so no wrap is possible.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == CNT8_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit; resets to 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Holds the PLL in reset, waits for lock with timeout/retries, requires stable lock before
// releasing the core reset, and re-initialises the PLL on lock loss. All outputs registered.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 8
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       lock_lost,
  output logic       fault,
  output logic [7:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  // A limit above 255 can never be reached by the saturating counter, so it behaves as unlimited.
  localparam bit         FAULT_EN = (MAX_RETRIES != 0) && (MAX_RETRIES <= 255);
  localparam logic [7:0] MAX_R8   = FAULT_EN ? 8'(MAX_RETRIES) : 8'd0;

  logic          locked_s;
  sup_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0]    retry_nx, loss_nx;
  logic          lost_nx, pll_rst_nx, sys_reset_n_nx, fault_nx;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      lock_lost   <= 1'b0;
      fault       <= 1'b0;
      retry_count <= 8'd0;
      loss_count  <= 8'd0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      pll_rst     <= pll_rst_nx;
      sys_reset_n <= sys_reset_n_nx;
      lock_lost   <= lost_nx;
      fault       <= fault_nx;
      retry_count <= retry_nx;
      loss_count  <= loss_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    retry_nx = retry_count;
    loss_nx  = loss_count;
    lost_nx  = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        // Lock is tested first so it wins over a timeout on the same edge.
        if (locked_s) begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end else if (cnt == TO_LAST) begin
          retry_nx = sat_inc8(retry_count);
          state_nx = (FAULT_EN && (retry_nx >= MAX_R8)) ? FAULT : PLL_RST;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == ST_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nx = PLL_RST;
          cnt_nx   = '0;
          lost_nx  = 1'b1;
          loss_nx  = sat_inc8(loss_count);
        end
      end
      FAULT: begin
        state_nx = FAULT;
      end
      default: begin
        state_nx = PLL_RST;
        cnt_nx   = '0;
      end
    endcase

    pll_rst_nx     = (state_nx == PLL_RST) || (state_nx == FAULT);
    sys_reset_n_nx = (state_nx == RUN);
    fault_nx       = (state_nx == FAULT);
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Lock supervisor on the free-running reference clock that drives the PLL's `rst` input and watches its `locked` output. It holds the PLL in reset after power-up and waits for lock with a timeout and bounded retries. It requires lock to be stable before releasing the system reset, and re-initialises the PLL when lock is lost. It sits between the board reference clock and the PLL wrapper, and its `sys_reset_n` feeds the per-domain reset synchronisers of the core.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchroniser; legal range ≥ 2.
- `PLL_RST_CYCLES`, 16: refclk cycles `pll_rst` is held high per attempt; legal range ≥ 1.
- `LOCK_TIMEOUT`, 50000: refclk cycles allowed for lock per attempt (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive locked cycles required before releasing reset.
- `MAX_RETRIES`, 8: failed attempts before FAULT; 0 means retry forever.

Ports:
- `refclk` in 1: free-running reference clock; the only clock.
- `rst_n` in 1: asynchronous active-low reset; deassertion is pre-synchronised externally.
- `pll_locked` in 1: raw PLL lock flag, asynchronous to `refclk`.
- `pll_rst` out 1: PLL reset, active-high, registered.
- `sys_reset_n` out 1: core reset request, active-low, registered.
- `lock_lost` out 1: one-cycle pulse when lock drops while in RUN.
- `fault` out 1: sticky; set when the retry limit is reached.
- `retry_count` out 8: timeouts since reset, saturating at 255.
- `loss_count` out 8: lock losses in RUN since reset, saturating at 255.

## Operation
- Reset values: `pll_rst`=1, `sys_reset_n`=0, `lock_lost`=0, `fault`=0, counters=0, state=PLL_RST, cycle counter=0.
- `pll_locked` passes through a SYNC_STAGES flop chain, giving `locked_s`. Only `locked_s` is used internally.
- States:
  - **PLL_RST**
    - `pll_rst`=1 and the cycle counter runs.
    - After PLL_RST_CYCLES cycles, go to WAIT_LOCK and clear the counter.
  - **WAIT_LOCK**
    - `pll_rst`=0.
    - If `locked_s`=1, go to STABLE and clear the counter.
    - Otherwise, when the counter reaches LOCK_TIMEOUT−1, the attempt has timed out:
      - increment `retry_count` (saturating);
      - if MAX_RETRIES≠0 and the new count ≥ MAX_RETRIES, go to FAULT;
      - otherwise go to PLL_RST.
  - **STABLE**
    - `pll_rst`=0.
    - If `locked_s`=0, go back to WAIT_LOCK and clear the counter. The timeout window restarts; `retry_count` is unchanged.
    - After STABLE_CYCLES consecutive cycles with `locked_s`=1, go to RUN.
  - **RUN**
    - `sys_reset_n`=1.
    - If `locked_s`=0:
      - `sys_reset_n` returns to 0 on the next edge;
      - `lock_lost` pulses for one cycle;
      - `loss_count` increments (saturating);
      - go to PLL_RST.
    - `retry_count` is not cleared.
  - **FAULT**
    - `pll_rst`=1, `sys_reset_n`=0, `fault`=1.
    - Only `rst_n` leaves this state.
- `sys_reset_n` is 1 only in RUN.
- Cycle counter width is $clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES, plus 1. No wrap is possible within a state.
- Asserting `rst_n` in any state takes effect immediately (asynchronously): all outputs return to their reset values, which raises `pll_rst` and drops `sys_reset_n`.

## Timing
- `pll_locked` rising to `locked_s` rising: SYNC_STAGES edges.
- `pll_rst` falls PLL_RST_CYCLES edges after the first edge following `rst_n` deassertion.
- Raw lock rising (held) in WAIT_LOCK to `sys_reset_n` rising: SYNC_STAGES + STABLE_CYCLES + 1 edges.
- Raw lock falling in RUN to `sys_reset_n` falling: SYNC_STAGES + 1 edges. `lock_lost` and `pll_rst` rise on the same edge.
- Timeout and lock detection on the same edge: lock wins, and the state goes to STABLE.
- A lock glitch shorter than one refclk cycle may be missed. This is acceptable.

## Structure
- Shared package `pll_sup_pkg`:
  - state enum (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT);
  - counter-width function.
- Sub-module `sync_bit` (parameter STAGES, async active-low reset to 0) for `pll_locked`. It is reusable elsewhere in the design.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3, SYNC_STAGES=2.
- **Nominal lock:** release `rst_n`, then raise `pll_locked` 3 cycles after `pll_rst` falls.
  - `pll_rst` falls at edge 4.
  - `sys_reset_n` rises 11 edges after `pll_locked` rises.
  - `retry_count`=0.
- **No lock:** keep `pll_locked`=0.
  - `pll_rst` pulses 3 times, 4 cycles each, 20-cycle waits between them.
  - `retry_count`=3, then `fault`=1 with `pll_rst` held at 1.
- **Unstable lock:** in STABLE, drop `pll_locked` for 3 cycles after 5 locked cycles.
  - State returns to WAIT_LOCK.
  - `retry_count` unchanged.
  - `sys_reset_n` still 0.
- **Lock loss in RUN:** drop `pll_locked` in RUN.
  - `sys_reset_n` falls and `lock_lost` pulses for 1 cycle, 3 edges after the drop.
  - `loss_count`=1.
  - A full PLL_RST/WAIT_LOCK/STABLE sequence follows.
- **Reset mid-STABLE:** assert `rst_n` while in STABLE.
  - Outputs return to reset values immediately (`pll_rst`=1, `sys_reset_n`=0, counters=0).
  - Sequence restarts from PLL_RST.
- **Saturation:** MAX_RETRIES=0 with 300 timeouts.
  - `retry_count` sticks at 255.
  - `fault` stays 0.
